// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths and record types for the reorder buffer.
package reorder_buffer_pkg;
    localparam int ROB_WIDTH = 3;
    localparam int REG_WIDTH = 5;
    localparam int ROB_DEPTH = 2**ROB_WIDTH;
    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;
    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic                 has_dest;
        logic [REG_WIDTH-1:0] arch_num;
        logic [31:0]          data;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: allocates tags at issue, captures CDB results, retires in order and serves bypass lookups.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_req,
    input  logic                      issue_has_dest,
    input  logic [REG_WIDTH-1:0]      issue_arch_num,
    output logic                      issue_ready,
    output logic [ROB_WIDTH-1:0]      issue_tag,
    input  logic                      cdb_valid,
    input  logic [ROB_WIDTH-1:0]      cdb_tag,
    input  logic [31:0]               cdb_data,
    input  logic [1:0][ROB_WIDTH-1:0] read_tag,
    output logic [1:0]                read_valid,
    output logic [1:0][31:0]          read_data,
    output logic                      retire,
    output logic                      commit,
    output logic [ROB_WIDTH-1:0]      commit_tag,
    output logic [REG_WIDTH-1:0]      commit_arch_num,
    output logic [31:0]               commit_data,
    output logic [ROB_WIDTH:0]        count
);
    localparam int CW = ROB_WIDTH + 1;

    rob_entry_t           rob_q [ROB_DEPTH];
    rob_entry_t           rob_d [ROB_DEPTH];
    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 do_issue;

    assign issue_ready     = count_q != CW'(ROB_DEPTH);
    assign issue_tag       = tail_q;
    assign do_issue        = issue_req && issue_ready && !reset;
    assign retire          = !reset && rob_q[head_q].busy && rob_q[head_q].done;
    assign commit          = retire && rob_q[head_q].has_dest;
    assign commit_tag      = head_q;
    assign commit_arch_num = rob_q[head_q].arch_num;
    assign commit_data     = rob_q[head_q].data;
    assign count           = count_q;

    always_comb begin
        rob_d = rob_q;
        if (retire) begin
            rob_d[head_q].busy = 1'b0;
            rob_d[head_q].done = 1'b0;
        end
        // The retiring head is already done, so a stray CDB hit on it must not resurrect it.
        if (cdb_valid && rob_q[cdb_tag].busy && !(retire && cdb_tag == head_q)) begin
            rob_d[cdb_tag].done = 1'b1;
            rob_d[cdb_tag].data = cdb_data;
        end
        if (do_issue)
            rob_d[tail_q] = '{busy: 1'b1, done: 1'b0, has_dest: issue_has_dest,
                              arch_num: issue_arch_num, data: '0};
        head_d  = head_q + ROB_WIDTH'(retire);
        tail_d  = tail_q + ROB_WIDTH'(do_issue);
        count_d = count_q + CW'(do_issue) - CW'(retire);
    end

    always_comb begin
        read_valid = '0;
        read_data  = '0;
        for (int i = 0; i < 2; i++) begin
            read_valid[i] = rob_q[read_tag[i]].busy &&
                            (rob_q[read_tag[i]].done || (cdb_valid && cdb_tag == read_tag[i]));
            read_data[i]  = (cdb_valid && cdb_tag == read_tag[i]) ? cdb_data : rob_q[read_tag[i]].data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++)
                rob_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rob_q   <= rob_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vectors, corner sequences and a queue-based random model for reorder_buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset, issue_req, issue_has_dest;
    logic [REG_WIDTH-1:0]      issue_arch_num;
    logic                      issue_ready;
    logic [ROB_WIDTH-1:0]      issue_tag;
    logic                      cdb_valid;
    logic [ROB_WIDTH-1:0]      cdb_tag;
    logic [31:0]               cdb_data;
    logic [1:0][ROB_WIDTH-1:0] read_tag;
    logic [1:0]                read_valid;
    logic [1:0][31:0]          read_data;
    logic                      retire, commit;
    logic [ROB_WIDTH-1:0]      commit_tag;
    logic [REG_WIDTH-1:0]      commit_arch_num;
    logic [31:0]               commit_data;
    logic [ROB_WIDTH:0]        count;

    int errors = 0;
    int checks = 0;

    reorder_buffer dut (
        .clk(clk), .reset(reset), .issue_req(issue_req), .issue_has_dest(issue_has_dest),
        .issue_arch_num(issue_arch_num), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .read_tag(read_tag), .read_valid(read_valid), .read_data(read_data),
        .retire(retire), .commit(commit), .commit_tag(commit_tag),
        .commit_arch_num(commit_arch_num), .commit_data(commit_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, hd;
        int          arch;
        logic        cv;
        int          ctag;
        logic [31:0] cdata;
        logic        e_ready;
        int          e_tag;
        logic        e_ret, e_com;
        int          e_ctag, e_carch;
        logic [31:0] e_cdata;
        int          e_count;
    } vec_t;

    typedef struct {
        int          tag;
        logic        hd;
        int          arch;
        logic        done;
        logic [31:0] data;
    } mentry_t;

    mentry_t mq[$];
    int      mtail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 0; issue_req = 0; issue_has_dest = 0; issue_arch_num = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0; read_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic run_random(input int cycles);
        logic        exp_ret, ready_b;
        logic        v;
        logic [31:0] d;
        int          head;
        for (int c = 0; c < cycles; c++) begin
            issue_req      = $urandom_range(0, 2) != 0;
            issue_has_dest = 1'($urandom);
            issue_arch_num = REG_WIDTH'($urandom);
            cdb_valid      = $urandom_range(0, 2) != 0;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_tag = ROB_WIDTH'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                cdb_tag = ROB_WIDTH'($urandom);
            cdb_data    = $urandom;
            read_tag[0] = ROB_WIDTH'($urandom);
            read_tag[1] = ROB_WIDTH'($urandom);
            reset       = $urandom_range(0, 199) == 0;
            #1;
            ready_b = mq.size() < ROB_DEPTH;
            exp_ret = !reset && mq.size() > 0 && mq[0].done;
            head    = mq.size() > 0 ? mq[0].tag : mtail;
            chk("rnd_ready", 32'(issue_ready), 32'(ready_b));
            chk("rnd_issue_tag", 32'(issue_tag), 32'(mtail));
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_retire", 32'(retire), 32'(exp_ret));
            chk("rnd_commit", 32'(commit), 32'(exp_ret && mq[0].hd));
            chk("rnd_commit_tag", 32'(commit_tag), 32'(head));
            if (exp_ret) begin
                chk("rnd_commit_arch", 32'(commit_arch_num), 32'(mq[0].arch));
                chk("rnd_commit_data", commit_data, mq[0].data);
            end
            for (int i = 0; i < 2; i++) begin
                v = 0;
                d = '0;
                foreach (mq[j])
                    if (mq[j].tag == int'(read_tag[i])) begin
                        v = mq[j].done || (cdb_valid && cdb_tag == read_tag[i]);
                        d = (cdb_valid && cdb_tag == read_tag[i]) ? cdb_data : mq[j].data;
                    end
                chk("rnd_read_valid", 32'(read_valid[i]), 32'(v));
                if (v) chk("rnd_read_data", read_data[i], d);
            end
            if (reset) begin
                mq.delete();
                mtail = 0;
            end else begin
                if (cdb_valid)
                    foreach (mq[j])
                        if (mq[j].tag == int'(cdb_tag) && !(j == 0 && exp_ret)) begin
                            mq[j].done = 1;
                            mq[j].data = cdb_data;
                        end
                if (exp_ret) void'(mq.pop_front());
                if (issue_req && ready_b) begin
                    mq.push_back('{tag: mtail, hd: issue_has_dest, arch: int'(issue_arch_num), done: 0, data: '0});
                    mtail = (mtail + 1) % ROB_DEPTH;
                end
            end
            tick();
        end
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1,1,1, 0,0,32'h00, 1,0, 0,0,0,0,32'h00, 0};
        vecs[1]  = '{1,1,2, 0,0,32'h00, 1,1, 0,0,0,0,32'h00, 1};
        vecs[2]  = '{1,1,3, 0,0,32'h00, 1,2, 0,0,0,0,32'h00, 2};
        vecs[3]  = '{0,0,0, 1,1,32'hAA, 1,3, 0,0,0,0,32'h00, 3};
        vecs[4]  = '{0,0,0, 1,0,32'h55, 1,3, 0,0,0,0,32'h00, 3};
        vecs[5]  = '{0,0,0, 0,0,32'h00, 1,3, 1,1,0,1,32'h55, 3};
        vecs[6]  = '{0,0,0, 0,0,32'h00, 1,3, 1,1,1,2,32'hAA, 2};
        vecs[7]  = '{0,0,0, 0,0,32'h00, 1,3, 0,0,2,0,32'h00, 1};
        vecs[8]  = '{0,0,0, 1,2,32'h77, 1,3, 0,0,2,0,32'h00, 1};
        vecs[9]  = '{0,0,0, 0,0,32'h00, 1,3, 1,1,2,3,32'h77, 1};
        vecs[10] = '{1,0,9, 0,0,32'h00, 1,3, 0,0,3,0,32'h00, 0};
        vecs[11] = '{0,0,0, 1,3,32'h99, 1,4, 0,0,3,0,32'h00, 1};
        vecs[12] = '{0,0,0, 0,0,32'h00, 1,4, 1,0,3,9,32'h99, 1};
        vecs[13] = '{0,0,0, 0,0,32'h00, 1,4, 0,0,4,0,32'h00, 0};

        do_reset();
        #1;
        chk("rst_ready", 32'(issue_ready), 1);
        chk("rst_tag", 32'(issue_tag), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_retire", 32'(retire), 0);

        foreach (vecs[k]) begin
            issue_req = vecs[k].req; issue_has_dest = vecs[k].hd;
            issue_arch_num = REG_WIDTH'(vecs[k].arch);
            cdb_valid = vecs[k].cv; cdb_tag = ROB_WIDTH'(vecs[k].ctag); cdb_data = vecs[k].cdata;
            #1;
            chk($sformatf("v%0d_ready", k), 32'(issue_ready), 32'(vecs[k].e_ready));
            chk($sformatf("v%0d_tag", k), 32'(issue_tag), 32'(vecs[k].e_tag));
            chk($sformatf("v%0d_retire", k), 32'(retire), 32'(vecs[k].e_ret));
            chk($sformatf("v%0d_commit", k), 32'(commit), 32'(vecs[k].e_com));
            chk($sformatf("v%0d_commit_tag", k), 32'(commit_tag), 32'(vecs[k].e_ctag));
            chk($sformatf("v%0d_count", k), 32'(count), 32'(vecs[k].e_count));
            if (vecs[k].e_ret) begin
                chk($sformatf("v%0d_commit_arch", k), 32'(commit_arch_num), 32'(vecs[k].e_carch));
                chk($sformatf("v%0d_commit_data", k), commit_data, vecs[k].e_cdata);
            end
            tick();
        end

        do_reset();
        for (int k = 0; k < ROB_DEPTH; k++) begin
            issue_req = 1; issue_has_dest = 1; issue_arch_num = REG_WIDTH'(k);
            #1;
            chk("fill_tag", 32'(issue_tag), 32'(k));
            tick();
        end
        cdb_valid = 1; cdb_tag = 0; cdb_data = 32'hE0;
        #1;
        chk("full_ready", 32'(issue_ready), 0);
        chk("full_count", 32'(count), 8);
        chk("full_retire", 32'(retire), 0);
        tick();
        cdb_valid = 0;
        #1;
        chk("full_hold_count", 32'(count), 8);
        chk("full_ret_retire", 32'(retire), 1);
        chk("full_ret_ready", 32'(issue_ready), 0);
        chk("full_ret_data", commit_data, 32'hE0);
        tick();
        #1;
        chk("wrap_ready", 32'(issue_ready), 1);
        chk("wrap_tag", 32'(issue_tag), 0);
        chk("wrap_count", 32'(count), 7);
        tick();
        issue_req = 0;
        #1;
        chk("refull_count", 32'(count), 8);
        chk("refull_ready", 32'(issue_ready), 0);
        chk("refull_tag", 32'(issue_tag), 1);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            issue_req = 1; issue_has_dest = 1; issue_arch_num = REG_WIDTH'(k + 1);
            tick();
        end
        issue_req = 0;
        read_tag[0] = 4; read_tag[1] = 3;
        cdb_valid = 1; cdb_tag = 4; cdb_data = 32'h1234;
        #1;
        chk("byp_cdb_valid", 32'(read_valid[0]), 1);
        chk("byp_cdb_data", read_data[0], 32'h1234);
        chk("byp_other_valid", 32'(read_valid[1]), 0);
        tick();
        cdb_valid = 0;
        #1;
        chk("byp_stored_valid", 32'(read_valid[0]), 1);
        chk("byp_stored_data", read_data[0], 32'h1234);
        chk("byp_head_retire", 32'(retire), 0);
        cdb_valid = 1; cdb_tag = 0; cdb_data = 32'h55;
        tick();
        reset = 1; cdb_valid = 1; cdb_tag = 1; cdb_data = 32'h66;
        #1;
        chk("rstmid_retire", 32'(retire), 0);
        chk("rstmid_commit", 32'(commit), 0);
        tick();
        idle();
        read_tag[0] = 1;
        #1;
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_ready", 32'(issue_ready), 1);
        chk("post_rst_tag", 32'(issue_tag), 0);
        chk("post_rst_head", 32'(commit_tag), 0);
        chk("post_rst_retire", 32'(retire), 0);
        chk("post_rst_read", 32'(read_valid[0]), 0);

        do_reset();
        mq.delete();
        mtail = 0;
        run_random(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
